mac_scheduler: RTL and testbench
================================

# mac_scheduler

Shared multiply-accumulate engine with round-robin arbitration. It lets up to NUM_REQ FIR channel sequencers (left/right audio, pilot, L−R, and so on) time-share one pipelined fixed-point multiplier. Each requester streams tap products tagged first/last. The block keeps a private accumulator per requester and writes each finished dot product, tagged with the requester id, into a downstream FIFO. It sits between the per-channel FIR control FSMs and the output FIFOs.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, operand/accumulator/result width, signed.
- QUANT_BITS, GLOBALS::BITS (10), fractional bits removed after each multiply.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester operand-valid; held with operands until granted.
- req_first  in  NUM_REQ  operand is first tap of a dot product.
- req_last  in  NUM_REQ  operand is last tap; result is emitted after it.
- req_a  in  NUM_REQ×DATA_WIDTH  sample operand, signed.
- req_b  in  NUM_REQ×DATA_WIDTH  coefficient operand, signed.
- gnt  out  NUM_REQ  one-hot (or zero) grant; operands are consumed in the cycle gnt is high.
- y_out  out  DATA_WIDTH  finished dot product, signed.
- y_id  out  $clog2(NUM_REQ)  requester index of y_out.
- y_out_wr_en  out  1  FIFO write strobe.
- y_out_full  in  1  downstream FIFO full.

## Operation
- Arbiter: combinational round-robin over req. Search starts at ptr. ptr becomes (granted index + 1) mod NUM_REQ on each grant. At most one grant per cycle. No grant while stalled.
- Pipeline S1: on grant, register a, b, id, first, last, valid.
- Pipeline S2: register the full 2·DATA_WIDTH signed product a·b, then dequantize it.
  - Dequantize = signed division by 2^QUANT_BITS, truncating toward zero (GLOBALS::DEQUANTIZE semantics).
  - Keep the low DATA_WIDTH bits of the result.
- Accumulate stage (S2 valid): sum = first ? p : acc[id] + p, with two's-complement wrap at DATA_WIDTH. acc[id] ← sum at the clock edge.
- Last handling: if last, drive y_out = sum, y_id = id, and y_out_wr_en = 1 when !y_out_full.
- Stall: S2 holds a last entry and y_out_full=1. While stalled:
  - S1 and S2 hold their contents.
  - gnt = 0.
  - acc is not written.
  - y_out_wr_en = 0.
- first and last both set: result is the single product.
- Operands with neither flag set, for a requester with no prior first, accumulate onto the stale acc. This is legal; no error is flagged.
- Interleaving: requesters may interleave arbitrarily. Back-to-back ops from one requester need no hazard logic, because acc read and write both occur in the single accumulate stage.

## Timing
- Reset values:
  - gnt=0, y_out_wr_en=0, y_out=0, y_id=0.
  - ptr=0.
  - S1/S2 valid=0.
  - All acc=0.
- Reset mid-operation discards in-flight products and partial sums. No result is emitted for them.
- Throughput: one product per cycle when not stalled.
- Latency:
  - Grant in cycle T → S1 valid T+1 → S2 valid and accumulate in T+2.
  - For a last op, y_out_wr_en is high in T+2 if not full.
- Full released in cycle U: write in U, and grants resume in U.
- Fairness: any requester holding req continuously is granted within NUM_REQ cycles, excluding stall cycles.

## Structure
- GLOBALS package holds BITS and DEQUANTIZE and is reused unchanged.
- Add mac_op_t (a, b, id, first, last, valid) to GLOBALS for the stage registers.
- One sub-module: rr_arbiter (NUM_REQ req → one-hot gnt, ptr register, enable input for stall).
- Accumulator array and pipeline registers stay in mac_scheduler.

## Test plan
- Single op, QUANT_BITS=10: requester 0, first=last=1, a=2048, b=1536 → y_out=3072, y_id=0, y_out_wr_en exactly 2 cycles after gnt.
- Rounding: a=−1000, b=3, first=last=1 → y_out=−2 (toward zero, not −3).
- Four-tap dot product on requester 2, all a=1024, b={1024,2048,−512,512}: three intermediate ops produce no write; last → y_out=3072, y_id=2.
- Round-robin: all 4 req held continuously with 8-op streams → grants cycle 0,1,2,3,0,…. Results emerge per id in order, values match a software model.
- Stall: hold y_out_full=1 when a last reaches S2 → gnt=0, pipeline frozen for 5 cycles. Deassert → write occurs that cycle, grants resume, no op lost or duplicated.
- Assert rst for one cycle mid-stream with partial sums in all acc → outputs at reset values, next first/last op on each id yields only its own product.

Source files
------------

// File: rtl/mac_scheduler_pkg.sv
// Shared fixed-point helpers and the MAC pipeline stage record.
// Stage fields are sized for the widest supported configuration.
package GLOBALS;
  localparam int BITS     = 10;
  localparam int OP_W     = 32;
  localparam int ID_MAX_W = 3;

  // Signed divide by 2^q, truncating toward zero.
  function automatic logic signed [2*OP_W-1:0] DEQUANTIZE(
    input logic signed [2*OP_W-1:0] v,
    input int                       q
  );
    logic signed [2*OP_W-1:0] bias;
    bias = '0;
    if (v[2*OP_W-1]) bias = {(2*OP_W){1'b1}} >> (2*OP_W - q);
    return (v + bias) >>> q;
  endfunction

  typedef struct packed {
    logic signed [OP_W-1:0] a;
    logic signed [OP_W-1:0] b;
    logic [ID_MAX_W-1:0]    id;
    logic                   first;
    logic                   last;
    logic                   valid;
  } mac_op_t;
endpackage

// File: rtl/mac_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, ptr moves past each winner.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);
  logic [ID_W-1:0] ptr, gidx;
  logic            found;
  int              idx;

  always_comb begin
    gnt   = '0;
    gidx  = ptr;
    found = 1'b0;
    idx   = 0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gidx     = ID_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (found)
      ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  end
endmodule

// File: rtl/mac_scheduler.sv
// Time-shared pipelined MAC: arbitrate, multiply, dequantize, accumulate
// per requester and emit finished dot products tagged with requester id.
module mac_scheduler import GLOBALS::*; #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int QUANT_BITS = BITS,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  req_first,
  input  logic [NUM_REQ-1:0]                  req_last,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [DATA_WIDTH-1:0]               y_out,
  output logic [ID_W-1:0]                     y_id,
  output logic                                y_out_wr_en,
  input  logic                                y_out_full
);
  mac_op_t s1, s1_nxt, s2, s2_nxt;

  logic                          stall, arb_en, s2_ok;
  logic [ID_W-1:0]               gidx, s2_idx;
  logic signed [DATA_WIDTH-1:0]  a_sel, b_sel;
  logic                          f_sel, l_sel;
  logic signed [2*DATA_WIDTH-1:0] mul_a, mul_b, s1_prod, s2_prod;
  logic signed [2*OP_W-1:0]      prod_ext;
  logic signed [DATA_WIDTH-1:0]  p, acc_cur, sum;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] acc;
  logic [NUM_REQ-1:0]            acc_we;

  // Arbitration is frozen while a finished result waits on the FIFO.
  assign arb_en = !stall && !rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (req),
    .gnt (gnt)
  );

  always_comb begin
    gidx  = '0;
    a_sel = '0;
    b_sel = '0;
    f_sel = 1'b0;
    l_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gidx  = ID_W'(i);
        a_sel = req_a[i];
        b_sel = req_b[i];
        f_sel = req_first[i];
        l_sel = req_last[i];
      end
    end
  end

  always_comb begin
    s1_nxt       = '0;
    s1_nxt.a     = OP_W'(a_sel);
    s1_nxt.b     = OP_W'(b_sel);
    s1_nxt.id    = ID_MAX_W'(gidx);
    s1_nxt.first = f_sel;
    s1_nxt.last  = l_sel;
    s1_nxt.valid = |gnt;
  end

  assign mul_a   = (2*DATA_WIDTH)'($signed(s1.a[DATA_WIDTH-1:0]));
  assign mul_b   = (2*DATA_WIDTH)'($signed(s1.b[DATA_WIDTH-1:0]));
  assign s1_prod = mul_a * mul_b;

  // In S2 the a:b fields carry the high:low halves of the full product.
  always_comb begin
    s2_nxt   = s1;
    s2_nxt.a = OP_W'(s1_prod[2*DATA_WIDTH-1:DATA_WIDTH]);
    s2_nxt.b = OP_W'(s1_prod[DATA_WIDTH-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else if (!stall) begin
      s1 <= s1_nxt;
      s2 <= s2_nxt;
    end
  end

  assign s2_prod  = $signed({s2.a[DATA_WIDTH-1:0], s2.b[DATA_WIDTH-1:0]});
  assign prod_ext = (2*OP_W)'(s2_prod);
  assign p        = DATA_WIDTH'(DEQUANTIZE(prod_ext, QUANT_BITS));

  assign s2_idx  = s2.id[ID_W-1:0];
  assign s2_ok   = s2.valid && ({1'b0, s2.id} < (ID_MAX_W + 1)'(NUM_REQ));
  assign acc_cur = acc[s2_idx];
  assign sum     = s2.first ? p : acc_cur + p;
  assign stall   = s2_ok && s2.last && y_out_full;

  assign y_out_wr_en = s2_ok && s2.last && !y_out_full;
  assign y_out       = (s2_ok && s2.last) ? sum : '0;
  assign y_id        = (s2_ok && s2.last) ? s2_idx : '0;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_acc
    assign acc_we[g] = s2_ok && !stall && (s2_idx == ID_W'(g));

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        acc[g] <= '0;
      else if (acc_we[g])
        acc[g] <= sum;
    end
  end
endmodule

// File: tb/tb_mac_scheduler.sv
// Directed bench for mac_scheduler: cycle-level reference model plus
// table-driven single-product vectors and multi-cycle corner sequences.
module tb_mac_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]         req, req_first, req_last, gnt;
  logic [N-1:0][DW-1:0] req_a, req_b;
  logic [DW-1:0]        y_out;
  logic [1:0]           y_id;
  logic                 y_out_wr_en, y_out_full;

  mac_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .QUANT_BITS(10)) dut (
    .clk(clk), .rst(rst), .req(req), .req_first(req_first), .req_last(req_last),
    .req_a(req_a), .req_b(req_b), .gnt(gnt), .y_out(y_out), .y_id(y_id),
    .y_out_wr_en(y_out_wr_en), .y_out_full(y_out_full)
  );

  typedef struct { int a; int b; bit first; bit last; } op_t;
  typedef struct { bit v; bit last; int id; int val; } pe_t;
  typedef struct { int id; int a; int b; int exp_y; } vec_t;

  op_t ops [N][128];
  int  head [N], tail [N];
  pe_t m1, m2;
  int  mptr, writes, total, bad;
  int  macc [N], act_y [N];
  bit  plan_stall;
  int  plan_g;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int deq(longint v);
    if (v < 0) return int'(-((-v) >>> 10));
    return int'(v >>> 10);
  endfunction

  task automatic push(int id, int a, int b, bit f, bit l);
    ops[id][tail[id]] = '{a, b, f, l};
    tail[id]++;
  endtask

  function automatic bit busy();
    bit r;
    r = m1.v || m2.v;
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) r = 1'b1;
    return r;
  endfunction

  // Reference model: check at negedge, advance at posedge, drive after.
  initial begin
    m1 = '{0, 0, 0, 0};
    m2 = '{0, 0, 0, 0};
    mptr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m1 = '{0, 0, 0, 0};
        m2 = '{0, 0, 0, 0};
        mptr = 0;
        for (int i = 0; i < N; i++) macc[i] = 0;
      end
      plan_stall = !rst && m2.v && m2.last && y_out_full;
      plan_g = -1;
      if (!rst && !plan_stall)
        for (int k = 0; k < N; k++)
          if (plan_g < 0 && req[(mptr + k) % N]) plan_g = (mptr + k) % N;
      chk("gnt", gnt, (plan_g < 0) ? 0 : (1 << plan_g));
      chk("wr_en", y_out_wr_en, (!rst && m2.v && m2.last && !y_out_full) ? 1 : 0);
      if (!rst && m2.v && m2.last && !y_out_full && y_out_wr_en) begin
        chk("y_out", longint'($signed(y_out)), m2.val);
        chk("y_id", y_id, m2.id);
        act_y[m2.id] = $signed(y_out);
        writes++;
      end
      if (rst) begin
        chk("rst_y_out", y_out, 0);
        chk("rst_y_id", y_id, 0);
      end
      @(posedge clk);
      if (!rst && !plan_stall) begin
        m2   = m1;
        m1.v = 1'b0;
        if (plan_g >= 0) begin
          op_t o;
          int  pr, s;
          o  = ops[plan_g][head[plan_g]];
          head[plan_g]++;
          pr = deq(longint'(o.a) * longint'(o.b));
          s  = o.first ? pr : macc[plan_g] + pr;
          macc[plan_g] = s;
          m1   = '{1'b1, o.last, plan_g, s};
          mptr = (plan_g + 1) % N;
        end
      end
      #1;
      for (int i = 0; i < N; i++) begin
        if (head[i] != tail[i]) begin
          req[i]       = 1'b1;
          req_a[i]     = ops[i][head[i]].a;
          req_b[i]     = ops[i][head[i]].b;
          req_first[i] = ops[i][head[i]].first;
          req_last[i]  = ops[i][head[i]].last;
        end else begin
          req[i] = 1'b0; req_a[i] = '0; req_b[i] = '0;
          req_first[i] = 1'b0; req_last[i] = 1'b0;
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      cycles(1);
      n++;
    end
    chk("drain_timeout", busy(), 0);
  endtask

  vec_t vecs [8];
  int   w0;

  initial begin
    total = 0; bad = 0; writes = 0;
    y_out_full = 1'b0;
    req = '0; req_first = '0; req_last = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; act_y[i] = 0; end

    vecs[0] = '{0, 2048, 1536, 3072};
    vecs[1] = '{1, -1000, 3, -2};
    vecs[2] = '{3, -1, 1, 0};
    vecs[3] = '{2, 1023, 1, 0};
    vecs[4] = '{1, -1024, 1, -1};
    vecs[5] = '{0, 32'h7fffffff, 2, 4194303};
    vecs[6] = '{3, -2048, -2048, 4096};
    vecs[7] = '{2, -1025, 1, -1};

    // Requests pending during reset must not be granted.
    push(0, 5, 7, 1'b1, 1'b1);
    cycles(3);
    rst = 1'b0;
    wait_idle(40);

    for (int v = 0; v < 8; v++) begin
      act_y[vecs[v].id] = 32'h5a5a5a5a;
      w0 = writes;
      push(vecs[v].id, vecs[v].a, vecs[v].b, 1'b1, 1'b1);
      wait_idle(40);
      chk($sformatf("vec%0d_y", v), act_y[vecs[v].id], vecs[v].exp_y);
      chk($sformatf("vec%0d_writes", v), writes - w0, 1);
    end

    // Four-tap dot product on requester 2.
    w0 = writes;
    act_y[2] = 0;
    push(2, 1024, 1024, 1'b1, 1'b0);
    push(2, 1024, 2048, 1'b0, 1'b0);
    push(2, 1024, -512, 1'b0, 1'b0);
    push(2, 1024, 512, 1'b0, 1'b1);
    wait_idle(40);
    chk("tap4_y", act_y[2], 3072);
    chk("tap4_writes", writes - w0, 1);

    // All requesters streaming: two 4-tap products each.
    w0 = writes;
    for (int i = 0; i < N; i++)
      for (int t = 0; t < 8; t++)
        push(i, int'($urandom_range(10000)) - 5000, int'($urandom_range(10000)) - 5000,
             (t % 4) == 0, (t % 4) == 3);
    wait_idle(100);
    chk("rr_writes", writes - w0, 8);

    // Downstream full while results arrive.
    w0 = writes;
    y_out_full = 1'b1;
    for (int i = 0; i < N; i++)
      for (int t = 0; t < 4; t++)
        push(i, 1024 * (i + 1), 1000 + t, t == 0, t == 3);
    cycles(20);
    chk("stall_no_write", writes - w0, 0);
    y_out_full = 1'b0;
    wait_idle(100);
    chk("stall_writes", writes - w0, 4);

    // Reset with partial sums in every accumulator.
    for (int i = 0; i < N; i++)
      for (int t = 0; t < 8; t++)
        push(i, 4096, 300 + t, t == 0, t == 7);
    cycles(8);
    rst = 1'b1;
    for (int i = 0; i < N; i++) head[i] = tail[i];
    cycles(1);
    rst = 1'b0;
    w0 = writes;
    for (int i = 0; i < N; i++) begin
      act_y[i] = 32'h5a5a5a5a;
      push(i, 1024, 100 * (i + 1), 1'b1, 1'b1);
    end
    wait_idle(60);
    for (int i = 0; i < N; i++) chk($sformatf("post_rst_y%0d", i), act_y[i], 100 * (i + 1));
    chk("post_rst_writes", writes - w0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
